// File: rtl/frame_stat_capture.sv
// Frame statistics capture: requests a frame from the upstream buffer and
// accumulates min/max/sum/count of its samples, then offers the result.
module frame_stat_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int SUM_WIDTH  = 32,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           expected_num,
    output logic                  request,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] res_min,
    output logic [DATA_WIDTH-1:0] res_max,
    output logic [SUM_WIDTH-1:0]  res_sum,
    output logic [31:0]           res_count,
    output logic                  err_len,
    output logic                  err_timeout,
    output logic                  res_valid,
    input  logic                  res_ready
);

    // Counter must be able to hold TIMEOUT itself after the final increment.
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TW-1:0]         tmo_cnt;
    logic                  in_frame;
    logic                  take;
    logic                  tmo_hit;
    logic [DATA_WIDTH-1:0] min_nxt;
    logic [DATA_WIDTH-1:0] max_nxt;
    logic [SUM_WIDTH-1:0]  sum_nxt;
    logic [31:0]           count_nxt;

    // Samples are only meaningful while a frame is being captured.
    assign in_frame = (state == REQ) || (state == ACC);
    assign take     = in_frame && in_valid;

    // Timeout fires on the TIMEOUT-th consecutive idle cycle; a frame end
    // arriving in that same cycle wins and is not reported as a timeout.
    assign tmo_hit = in_frame && !in_valid && !in_last
                     && (tmo_cnt == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (in_last) begin
                    state_nxt = DONE;
                end else if (in_valid) begin
                    state_nxt = ACC;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            ACC: begin
                if (in_last || tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; all come straight from the state register.
    always_comb begin
        request   = (state == REQ);
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    // Statistics after folding in the current sample, if any.
    always_comb begin
        min_nxt   = res_min;
        max_nxt   = res_max;
        sum_nxt   = res_sum;
        count_nxt = res_count;
        if (take) begin
            if (state == REQ) begin
                min_nxt = in_data;
                max_nxt = in_data;
            end else begin
                if (in_data < res_min) begin
                    min_nxt = in_data;
                end
                if (in_data > res_max) begin
                    max_nxt = in_data;
                end
            end
            sum_nxt   = res_sum + SUM_WIDTH'(in_data);
            count_nxt = res_count + 32'd1;
        end
    end

    // Result, error and timeout registers; held through DONE and IDLE.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            res_min     <= '0;
            res_max     <= '0;
            res_sum     <= '0;
            res_count   <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        res_min     <= '0;
                        res_max     <= '0;
                        res_sum     <= '0;
                        res_count   <= '0;
                        err_len     <= 1'b0;
                        err_timeout <= 1'b0;
                        tmo_cnt     <= '0;
                    end
                end
                REQ, ACC: begin
                    res_min   <= min_nxt;
                    res_max   <= max_nxt;
                    res_sum   <= sum_nxt;
                    res_count <= count_nxt;
                    if (take) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    if (state_nxt == DONE) begin
                        err_len     <= (count_nxt != expected_num);
                        err_timeout <= tmo_hit;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stat_capture.sv
// Randomised scoreboard bench for frame_stat_capture with a queue-based
// reference model and a decoupled result monitor.
module tb_frame_stat_capture;

    localparam int DW = 12;
    localparam int SW = 32;
    localparam int TO = 16;

    logic          rd_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   expected_num = '0;
    logic          request;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          busy;
    logic [DW-1:0] res_min;
    logic [DW-1:0] res_max;
    logic [SW-1:0] res_sum;
    logic [31:0]   res_count;
    logic          err_len;
    logic          err_timeout;
    logic          res_valid;
    logic          res_ready = 1'b0;

    typedef struct {
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic [SW-1:0] sum;
        logic [31:0]   cnt;
        logic          el;
        logic          et;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 0;
    logic prev_v = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   smp[$];
    int   none[$];

    frame_stat_capture #(
        .DATA_WIDTH(DW),
        .SUM_WIDTH(SW),
        .TIMEOUT(TO)
    ) dut (
        .rd_clk(rd_clk),
        .rst_n(rst_n),
        .start(start),
        .expected_num(expected_num),
        .request(request),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .busy(busy),
        .res_min(res_min),
        .res_max(res_max),
        .res_sum(res_sum),
        .res_count(res_count),
        .err_len(err_len),
        .err_timeout(err_timeout),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Reference: statistics straight from the list of accepted samples.
    function automatic exp_t model(input int s[$], input logic [31:0] expn,
                                   input bit tmo, input int due);
        exp_t e;
        int mn;
        int mx;
        logic [SW-1:0] sum;
        mn = 0;
        mx = 0;
        sum = '0;
        foreach (s[i]) begin
            if (i == 0 || s[i] < mn) mn = s[i];
            if (i == 0 || s[i] > mx) mx = s[i];
            sum = sum + SW'(s[i]);
        end
        e.mn  = DW'(mn);
        e.mx  = DW'(mx);
        e.sum = sum;
        e.cnt = 32'(s.size());
        e.el  = (e.cnt != expn);
        e.et  = tmo;
        e.due = due;
        return e;
    endfunction

    // Monitor: pops one expectation per result and checks it while offered.
    always @(negedge rd_clk) begin
        if (!rst_n) begin
            prev_v   = 1'b0;
            have_cur = 0;
        end else begin
            if (res_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(res_valid), 64'(0));
                    have_cur = 0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1;
                    chk("latency", 64'(cyc), 64'(cur.due));
                end
            end
            if (res_valid && have_cur) begin
                chk("res_min", 64'(res_min), 64'(cur.mn));
                chk("res_max", 64'(res_max), 64'(cur.mx));
                chk("res_sum", 64'(res_sum), 64'(cur.sum));
                chk("res_count", 64'(res_count), 64'(cur.cnt));
                chk("err_len", 64'(err_len), 64'(cur.el));
                chk("err_timeout", 64'(err_timeout), 64'(cur.et));
            end
            prev_v = res_valid;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_request"}, 64'(request), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_err_len"}, 64'(err_len), 64'(0));
        chk({tag, "_err_tmo"}, 64'(err_timeout), 64'(0));
        chk({tag, "_min"}, 64'(res_min), 64'(0));
        chk({tag, "_max"}, 64'(res_max), 64'(0));
        chk({tag, "_sum"}, 64'(res_sum), 64'(0));
        chk({tag, "_count"}, 64'(res_count), 64'(0));
    endtask

    // Called one cycle after the terminating event (result on offer).
    task automatic finish(input exp_t e, input int rdly);
        if (rdly == 0) begin
            res_ready = 1'b1;
            tick();
        end else begin
            for (int k = 0; k < rdly; k++) begin
                chk("done_hold", 64'(res_valid), 64'(1));
                in_valid = 1'($urandom);
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
                start    = 1'($urandom);
                res_ready = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
            chk("done_hold", 64'(res_valid), 64'(1));
            res_ready = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_valid", 64'(res_valid), 64'(0));
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = DW'($urandom);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("idle_ignore", 64'(busy), 64'(0));
        chk("idle_min", 64'(res_min), 64'(e.mn));
        chk("idle_max", 64'(res_max), 64'(e.mx));
        chk("idle_sum", 64'(res_sum), 64'(e.sum));
        chk("idle_count", 64'(res_count), 64'(e.cnt));
    endtask

    task automatic run_frame(input logic [31:0] expn, input bit last_alone,
                             input int rdly);
        exp_t e;
        int n;
        bit la;
        n = smp.size();
        la = last_alone || (n == 0);
        expected_num = expn;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("req_rise", 64'(request), 64'(1));
        chk("busy_rise", 64'(busy), 64'(1));
        repeat ($urandom_range(0, 3)) tick();
        chk("req_hold", 64'(request), 64'(1));
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(smp[i]);
            in_last  = !la && (i == n - 1);
            if (in_last) begin
                e = model(smp, expn, 0, cyc + 1);
                q.push_back(e);
                res_ready = (rdly == 0);
            end
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i == 0) chk("req_fall", 64'(request), 64'(0));
            if (i < n - 1) repeat ($urandom_range(0, 2)) tick();
        end
        if (la) begin
            in_last = 1'b1;
            e = model(smp, expn, 0, cyc + 1);
            q.push_back(e);
            res_ready = (rdly == 0);
            tick();
            in_last = 1'b0;
        end
        finish(e, rdly);
    endtask

    task automatic timeout_frame(input logic [31:0] expn, input int rdly);
        exp_t e;
        int w;
        expected_num = expn;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = model(none, expn, 1, cyc + TO);
        q.push_back(e);
        w = 0;
        while (!res_valid && w < TO + 4) begin
            tick();
            w++;
        end
        chk("tmo_reached", 64'(res_valid), 64'(1));
        chk("tmo_request", 64'(request), 64'(0));
        finish(e, rdly);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int expn;
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        smp = '{5, 2, 9, 7};
        run_frame(4, 0, 0);

        smp = '{1, 1, 1};
        run_frame(4, 0, 3);

        timeout_frame(4, 2);

        smp = '{3, 8};
        run_frame(2, 0, 10);

        smp = {};
        run_frame(0, 1, 1);

        smp = {};
        for (int i = 0; i < 8; i++) smp.push_back(4095);
        run_frame(8, 0, 0);

        expected_num = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_zero("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(20 + i);
            in_last  = (i == 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check_zero("postreset");

        smp = '{6, 1, 4, 3};
        run_frame(4, 0, 0);

        repeat (25) begin
            n = $urandom_range(0, 10);
            smp = {};
            for (int i = 0; i < n; i++) smp.push_back($urandom_range(0, 4095));
            expn = n + $urandom_range(0, 2) - 1;
            run_frame(32'(expn), 1'($urandom), $urandom_range(0, 4));
        end

        timeout_frame(0, 0);

        repeat (3) tick();
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_stat_capture.md
FRAME_STAT_CAPTURE -- requirements
Module: frame_stat_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, sample width.
REQ-002 SHALL have parameter SUM_WIDTH, default 32, accumulator width.
REQ-003 SHALL have parameter TIMEOUT, default 1048576, maximum idle rd_clk cycles allowed in REQ/ACC.
REQ-004 SHALL have port rd_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle capture command.
REQ-007 SHALL have port expected_num  input  32  expected sample count per frame.
REQ-008 SHALL have port request  output  1  capture request to the upstream frame buffer.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  sample from the upstream buffer.
REQ-010 SHALL have port in_valid  input  1  in_data qualifier.
REQ-011 SHALL have port in_last  input  1  end-of-frame marker.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have ports res_min, res_max  output  DATA_WIDTH  frame minimum and maximum.
REQ-014 SHALL have port res_sum  output  SUM_WIDTH  frame sample sum.
REQ-015 SHALL have port res_count  output  32  samples accepted this frame.
REQ-016 SHALL have ports err_len, err_timeout  output  1  length mismatch; timeout abort.
REQ-017 SHALL have ports res_valid  output  1, res_ready  input  1  result handshake.

Function
REQ-018 SHALL implement FSM IDLE, REQ, ACC, DONE.
REQ-019 IDLE: start=1 -> REQ next cycle; clear min/max/sum/count, err flags, timeout counter.
REQ-020 REQ: request=1 (registered, rises the cycle after start); stays high until the first in_valid, then deasserts and FSM -> ACC.
REQ-021 The in_valid sample that ends REQ SHALL be accumulated, and it initialises min and max.
REQ-022 ACC: each in_valid updates min, max, count+1, sum+in_data (unsigned, wraps modulo 2^SUM_WIDTH).
REQ-023 in_valid and in_last in the same cycle (REQ or ACC): include the sample, then -> DONE.
REQ-024 in_last without in_valid: no sample added, -> DONE.
REQ-025 Timeout counter SHALL clear on every in_valid and increment otherwise in REQ/ACC; on reaching TIMEOUT -> DONE with err_timeout=1 and request=0.
REQ-026 On entry to DONE, err_len SHALL be set if res_count != expected_num (timeout exit included).
REQ-027 DONE: res_valid=1 from the cycle after the terminating event; all res_* and err_* held stable until res_valid && res_ready, then -> IDLE and res_valid=0.
REQ-028 res_ready in the same cycle res_valid first rises SHALL complete the handshake (one-cycle DONE).
REQ-029 res_* and err_* SHALL remain valid in IDLE until the next start.
REQ-030 Zero-sample frame SHALL report res_min=0, res_max=0, res_sum=0, res_count=0.
REQ-031 start outside IDLE SHALL be ignored; in_valid/in_last in IDLE or DONE SHALL be ignored.
REQ-032 Latency: terminating in_valid/in_last at cycle t -> res_valid=1 at t+1.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE; request, busy, res_valid, err_len, err_timeout = 0; res_min, res_max, res_sum, res_count = 0; timeout counter = 0.
REQ-034 Reset mid-frame SHALL discard partial results; samples arriving after reset release without start SHALL be ignored.

Verification
REQ-035 expected_num=4, start, samples 5,2,9,7 with in_last on 7 -> min=2, max=9, sum=23, count=4, err_len=0, res_valid one cycle after last.
REQ-036 expected_num=4, 3 samples 1,1,1 with in_last on third -> count=3, sum=3, err_len=1.
REQ-037 TIMEOUT=16, start, no in_valid -> after 16 idle cycles res_valid=1, err_timeout=1, count=0, request=0.
REQ-038 res_ready held low 10 cycles in DONE, in_valid toggled and start pulsed -> outputs unchanged, state stays DONE; res_ready=1 -> IDLE next cycle.
REQ-039 Reset asserted after 2 of 4 samples -> all outputs 0; remaining samples ignored; new start yields correct fresh frame.
REQ-040 DATA_WIDTH=12, 8 samples of 4095 -> max=4095, min=4095, sum=32760.
